// File: rtl/ball_sprite_scan_if.sv
// ball_sprite_scan_if: raster-in / mask-lookup / composited-pixel-out bundle for the ball sprite stage.
interface ball_sprite_scan_if #(parameter int COLOR_W = 12);
    logic [9:0]         h_cnt;
    logic [9:0]         v_cnt;
    logic               valid;
    logic [9:0]         ball_x;
    logic [9:0]         ball_y;
    logic [COLOR_W-1:0] ball_color;
    logic [COLOR_W-1:0] bg_pixel;
    logic [15:0]        mask_pos;
    logic               mask_white;
    logic [COLOR_W-1:0] pixel_out;
    logic               pixel_valid;
    logic [11:0]        ball_pix_cnt;
    logic               frame_tick;
    modport master (
        output h_cnt, v_cnt, valid, ball_x, ball_y, ball_color, bg_pixel, mask_white,
        input  mask_pos, pixel_out, pixel_valid, ball_pix_cnt, frame_tick
    );
    modport slave (
        input  h_cnt, v_cnt, valid, ball_x, ball_y, ball_color, bg_pixel, mask_white,
        output mask_pos, pixel_out, pixel_valid, ball_pix_cnt, frame_tick
    );
endinterface

// File: rtl/ball_sprite_scan.sv
// ball_sprite_scan: 2-stage raster-to-sprite-mask pipeline compositing the ball over the background and counting ball pixels per frame.
module ball_sprite_scan #(
    parameter int SPR_W    = 50,
    parameter int SPR_H    = 50,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int COLOR_W  = 12
) (
    input logic clk,
    input logic rst,
    ball_sprite_scan_if.slave bus
);
    logic [9:0]         sx_q, sy_q;
    logic [10:0]        dx, dy;
    logic               boundary, in_win, draw;
    logic [15:0]        pos_d, pos_q;
    logic               in_win_q, valid_q, pix_valid_q, tick_q;
    logic [COLOR_W-1:0] bg_q, pix_d, pix_q;
    logic [11:0]        run_d, run_q, cnt_q;
    always_comb begin
        boundary = bus.h_cnt == 10'd0 && bus.v_cnt == 10'(V_ACTIVE);
        dx       = {1'b0, bus.h_cnt} - {1'b0, sx_q};
        dy       = {1'b0, bus.v_cnt} - {1'b0, sy_q};
        in_win   = bus.valid && bus.h_cnt < 10'(H_ACTIVE) && bus.h_cnt >= sx_q && dx < 11'(SPR_W)
                   && bus.v_cnt >= sy_q && dy < 11'(SPR_H);
        pos_d    = in_win ? 16'(dy) * 16'(SPR_W) + 16'(dx) : 16'd0;
        draw     = valid_q && in_win_q && !bus.mask_white;
        pix_d    = !valid_q ? '0 : draw ? bus.ball_color : bg_q;
        // a ball pixel landing on the boundary cycle belongs to the new frame
        run_d    = boundary ? {11'd0, draw} : run_q + {11'd0, draw && run_q != 12'hFFF};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx_q        <= '0;
            sy_q        <= '0;
            pos_q       <= '0;
            in_win_q    <= 1'b0;
            valid_q     <= 1'b0;
            bg_q        <= '0;
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
            run_q       <= '0;
            cnt_q       <= '0;
            tick_q      <= 1'b0;
        end else begin
            if (boundary) begin
                sx_q  <= bus.ball_x;
                sy_q  <= bus.ball_y;
                cnt_q <= run_q;
            end
            pos_q       <= pos_d;
            in_win_q    <= in_win;
            valid_q     <= bus.valid;
            bg_q        <= bus.bg_pixel;
            pix_q       <= pix_d;
            pix_valid_q <= valid_q;
            run_q       <= run_d;
            tick_q      <= boundary;
        end
    end
    assign bus.mask_pos     = pos_q;
    assign bus.pixel_out    = pix_q;
    assign bus.pixel_valid  = pix_valid_q;
    assign bus.ball_pix_cnt = cnt_q;
    assign bus.frame_tick   = tick_q;
endmodule
